// File: rtl/id_ex_pkg.sv
// Shared constants for the ID/EX stage: ALU operation codes, opcode/funct values
// and the decoded-control bundle passed from the decoder to the pipeline register.
package id_ex_pkg;

    // ALU operation codes; these must stay identical to the ALU's own table.
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_MUL  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd6;
    localparam logic [4:0] ALU_OR   = 5'd7;
    localparam logic [4:0] ALU_XOR  = 5'd8;
    localparam logic [4:0] ALU_BGEZ = 5'd11;
    localparam logic [4:0] ALU_BEQ  = 5'd12;
    localparam logic [4:0] ALU_NOR  = 5'd13;
    localparam logic [4:0] ALU_SLT  = 5'd14;
    localparam logic [4:0] ALU_BNE  = 5'd15;
    localparam logic [4:0] ALU_BGTZ = 5'd16;
    localparam logic [4:0] ALU_BLEZ = 5'd17;
    localparam logic [4:0] ALU_BLTZ = 5'd18;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_MUL  = 6'h02;

    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;

    typedef enum logic [0:0] {A_RS, A_RT} a_sel_e;
    typedef enum logic [2:0] {B_RT, B_RS, B_SHAMT, B_SEXT, B_ZEXT, B_ZERO} b_sel_e;
    typedef enum logic [1:0] {WR_NONE, WR_RD, WR_RT} wr_sel_e;

    typedef struct packed {
        logic [4:0] alu_ctrl;
        a_sel_e     a_sel;
        b_sel_e     b_sel;
        wr_sel_e    wr_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// Combinational decode of opcode/funct/rt into ALU code, operand selects and
// downstream control bits. Unknown encodings collapse to an illegal-op NOP.
module alu_ctrl_decode
    import id_ex_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] rt_i,
    output dec_t       dec_o
);

    logic bad;

    always_comb begin
        bad             = 1'b0;
        dec_o           = '0;
        dec_o.a_sel     = A_RS;
        dec_o.b_sel     = B_RT;
        dec_o.wr_sel    = WR_NONE;
        case (opcode_i)
            OP_RTYPE: begin
                dec_o.wr_sel    = WR_RD;
                dec_o.reg_write = 1'b1;
                case (funct_i)
                    F_ADD, F_ADDU: dec_o.alu_ctrl = ALU_ADD;
                    F_SUB:         dec_o.alu_ctrl = ALU_SUB;
                    F_AND:         dec_o.alu_ctrl = ALU_AND;
                    F_OR:          dec_o.alu_ctrl = ALU_OR;
                    F_XOR:         dec_o.alu_ctrl = ALU_XOR;
                    F_NOR:         dec_o.alu_ctrl = ALU_NOR;
                    F_SLT:         dec_o.alu_ctrl = ALU_SLT;
                    F_SLL, F_SRL: begin
                        dec_o.alu_ctrl = (funct_i == F_SLL) ? ALU_SLL : ALU_SRL;
                        dec_o.a_sel    = A_RT;
                        dec_o.b_sel    = B_SHAMT;
                    end
                    F_SLLV, F_SRLV: begin
                        dec_o.alu_ctrl = (funct_i == F_SLLV) ? ALU_SLL : ALU_SRL;
                        dec_o.a_sel    = A_RT;
                        dec_o.b_sel    = B_RS;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                dec_o.alu_ctrl  = ALU_MUL;
                dec_o.wr_sel    = WR_RD;
                dec_o.reg_write = 1'b1;
                bad             = (funct_i != F_MUL);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_o.wr_sel    = WR_RT;
                dec_o.reg_write = 1'b1;
                dec_o.b_sel     = B_SEXT;
                case (opcode_i)
                    OP_SLTI: dec_o.alu_ctrl = ALU_SLT;
                    OP_ANDI: begin dec_o.alu_ctrl = ALU_AND; dec_o.b_sel = B_ZEXT; end
                    OP_ORI:  begin dec_o.alu_ctrl = ALU_OR;  dec_o.b_sel = B_ZEXT; end
                    OP_XORI: begin dec_o.alu_ctrl = ALU_XOR; dec_o.b_sel = B_ZEXT; end
                    default: dec_o.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec_o.alu_ctrl   = ALU_ADD;
                dec_o.b_sel      = B_SEXT;
                dec_o.wr_sel     = WR_RT;
                dec_o.reg_write  = 1'b1;
                dec_o.mem_read   = 1'b1;
                dec_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_o.alu_ctrl  = ALU_ADD;
                dec_o.b_sel     = B_SEXT;
                dec_o.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_o.alu_ctrl = (opcode_i == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                dec_o.branch   = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                dec_o.alu_ctrl = (opcode_i == OP_BLEZ) ? ALU_BLEZ : ALU_BGTZ;
                dec_o.b_sel    = B_ZERO;
                dec_o.branch   = 1'b1;
            end
            OP_REGIMM: begin
                dec_o.b_sel  = B_ZERO;
                dec_o.branch = 1'b1;
                case (rt_i)
                    RT_BGEZ: dec_o.alu_ctrl = ALU_BGEZ;
                    RT_BLTZ: dec_o.alu_ctrl = ALU_BLTZ;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec_o         = '0;
            dec_o.a_sel   = A_RS;
            dec_o.b_sel   = B_ZERO;
            dec_o.wr_sel  = WR_NONE;
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand muxing/extension, flush/stall
// priority and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [5:0]        ID_Opcode,
    input  logic [5:0]        ID_Funct,
    input  logic [4:0]        ID_Shamt,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [15:0]       ID_Imm,
    input  logic [DATA_W-1:0] ID_RsData,
    input  logic [DATA_W-1:0] ID_RtData,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    output logic              EX_Valid,
    output logic [4:0]        EX_ALUControl,
    output logic [DATA_W-1:0] EX_A,
    output logic [DATA_W-1:0] EX_B,
    output logic [DATA_W-1:0] EX_StoreData,
    output logic [4:0]        EX_WriteReg,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemToReg,
    output logic              EX_Branch,
    output logic              EX_IllegalOp,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [CNT_W-1:0]  BubbleCount
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        alu_ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] store;
        logic [4:0]        wreg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              illegal;
        logic [DATA_W-1:0] pc4;
    } ex_t;

    dec_t             dec;
    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic             bubble;

    alu_ctrl_decode u_decode (
        .opcode_i (ID_Opcode),
        .funct_i  (ID_Funct),
        .rt_i     (ID_Rt),
        .dec_o    (dec)
    );

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = 1'b1;
        ex_d.alu_ctrl = dec.alu_ctrl;
        ex_d.pc4      = ID_PCPlus4;
        ex_d.a        = (dec.a_sel == A_RT) ? ID_RtData : ID_RsData;
        case (dec.b_sel)
            B_RT:    ex_d.b = ID_RtData;
            B_RS:    ex_d.b = ID_RsData;
            B_SHAMT: ex_d.b = {{(DATA_W-5){1'b0}}, ID_Shamt};
            B_SEXT:  ex_d.b = {{(DATA_W-16){ID_Imm[15]}}, ID_Imm};
            B_ZEXT:  ex_d.b = {{(DATA_W-16){1'b0}}, ID_Imm};
            default: ex_d.b = '0;
        endcase
        case (dec.wr_sel)
            WR_RD:   ex_d.wreg = ID_Rd;
            WR_RT:   ex_d.wreg = ID_Rt;
            default: ex_d.wreg = 5'd0;
        endcase
        // Illegal ops carry no operands; only valid, the flag and PC+4 survive.
        if (dec.illegal) begin
            ex_d.a = '0;
        end else begin
            ex_d.store = ID_RtData;
        end
        ex_d.reg_write  = dec.reg_write && (ex_d.wreg != 5'd0);
        ex_d.mem_read   = dec.mem_read;
        ex_d.mem_write  = dec.mem_write;
        ex_d.mem_to_reg = dec.mem_to_reg;
        ex_d.branch     = dec.branch;
        ex_d.illegal    = dec.illegal;
    end

    assign bubble = Flush || (!Stall && !ID_Valid);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (bubble) begin
            ex_q <= '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (!Stall) begin
            ex_q <= ex_d;
        end
    end

    assign EX_Valid      = ex_q.valid;
    assign EX_ALUControl = ex_q.alu_ctrl;
    assign EX_A          = ex_q.a;
    assign EX_B          = ex_q.b;
    assign EX_StoreData  = ex_q.store;
    assign EX_WriteReg   = ex_q.wreg;
    assign EX_RegWrite   = ex_q.reg_write;
    assign EX_MemRead    = ex_q.mem_read;
    assign EX_MemWrite   = ex_q.mem_write;
    assign EX_MemToReg   = ex_q.mem_to_reg;
    assign EX_Branch     = ex_q.branch;
    assign EX_IllegalOp  = ex_q.illegal;
    assign EX_PCPlus4    = ex_q.pc4;
    assign BubbleCount   = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit ALU.
- Decodes opcode/funct into the ALU's 5-bit ALUControl code.
- Selects and extends ALU operands A/B, registers them with the downstream control bits.
- Supports stall (hold) and flush (bubble insert), and keeps a saturating bubble counter.

Parameters:
- DATA_W, 32, operand/PC width.
- CNT_W, 16, bubble-counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- Stall  in  1  hold all EX_* registers.
- Flush  in  1  load bubble.
- ID_Valid  in  1  ID holds a real instruction.
- ID_Opcode  in  6  instr[31:26].
- ID_Funct  in  6  instr[5:0].
- ID_Shamt  in  5  instr[10:6].
- ID_Rt, ID_Rd  in  5 each  register specifiers.
- ID_Imm  in  16  instr[15:0].
- ID_RsData, ID_RtData  in  DATA_W each  register-file read data.
- ID_PCPlus4  in  DATA_W  PC+4.
- EX_Valid  out  1  registered valid.
- EX_ALUControl  out  5  ALU operation code.
- EX_A, EX_B  out  DATA_W each  ALU operands.
- EX_StoreData  out  DATA_W  registered rt data for sw.
- EX_WriteReg  out  5  destination register.
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_Branch, EX_IllegalOp  out  1 each  control bits.
- EX_PCPlus4  out  DATA_W  registered PC+4.
- BubbleCount  out  CNT_W  saturating bubble count.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (Reset_n=0 at edge): every output is 0, including BubbleCount.
- Priority at each edge: Reset_n low > Flush > Stall > load.
- Latency: ID inputs appear on EX_* one cycle after a load edge.
- Bubble: loaded on Flush=1, or on ID_Valid=0 with Stall=0. A bubble clears all EX_* outputs (data included) to 0; ALUControl=0 is NOP.
- Stall=1, Flush=0: all EX_* and BubbleCount hold. Flush overrides Stall.
- BubbleCount: +1 on every edge that loads a bubble; saturates at all-ones; no wrap.
- ALUControl codes: ADD 1, SUB 2, MUL 3, SLL 4, SRL 5, AND 6, OR 7, XOR 8, BGEZ 11, BEQ 12, NOR 13, SLT 14, BNE 15, BGTZ 16, BLEZ 17, BLTZ 18.
- R-type (op 0x00), A=rs, B=rt, WriteReg=rd, RegWrite=1, by funct: 20/21 ADD; 22 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT.
- Constant shifts: funct 00 SLL and 02 SRL use A=rt, B=zero-extended shamt.
- Variable shifts: funct 04 SLLV and 06 SRLV use A=rt, B=rs.
- mul: op 0x1C with funct 0x02 gives MUL, A=rs, B=rt, WriteReg=rd.
- I-type ALU ops: A=rs, WriteReg=rt, RegWrite=1.
  - addi 08 / addiu 09: ADD.
  - slti 0A: SLT.
  - B is the sign-extended Imm for all three.
  - andi 0C AND, ori 0D OR, xori 0E XOR: B is the zero-extended Imm.
- lw 0x23: ADD, sign-extended Imm, MemRead=1, MemToReg=1, RegWrite=1, WriteReg=rt.
- sw 0x2B: ADD, sign-extended Imm, MemWrite=1, StoreData=rt data.
- Compare branches, Branch=1, RegWrite=0: beq 04 BEQ and bne 05 BNE use A=rs, B=rt.
- Zero-compare branches, A=rs, B=0, Branch=1, RegWrite=0: blez 06 BLEZ; bgtz 07 BGTZ; op 01 with rt=01 BGEZ; op 01 with rt=00 BLTZ.
- Any other opcode/funct/rt combination:
  - IllegalOp=1, ALUControl=0, Valid=1.
  - All write/memory/branch controls are 0.
- RegWrite is forced 0 when WriteReg==0, so the all-zero nop is harmless.
- Reset asserted mid-stall or mid-flush: reset wins and zeroes outputs the same cycle.

Decomposition:
- Package id_ex_pkg holds:
  - ALUControl code localparams, which must match the ALU exactly.
  - Opcode and funct localparams.
- Sub-module alu_ctrl_decode: combinational decode of opcode/funct/rt into ALUControl, operand-select and control bits.
- id_ex_stage keeps only the operand muxing, registers, priority logic and counter.

Test Plan:
- Reset_n=0 for 2 edges with random inputs -> all outputs 0, BubbleCount=0.
- add: rs=5, rt=7, rd=3, funct 0x20 -> next edge ALUControl=1, A=5, B=7, WriteReg=3, RegWrite=1.
- addi with Imm=0xFFFF, then andi with Imm=0xFFFF -> addi gives B=0xFFFFFFFF, ALUControl=1; andi gives B=0x0000FFFF, ALUControl=6.
- sll with shamt=4, rt=0x1 -> A=0x1, B=4, ALUControl=4.
- bgez (op 01, rt=01), rs=0x10 -> ALUControl=11, A=0x10, B=0, Branch=1, RegWrite=0.
- Load lw, then Stall=1 for 3 cycles with changing inputs -> outputs hold the lw values.
- Next: Flush=1 and Stall=1 together -> bubble, EX_Valid=0, BubbleCount +1.
- Illegal opcode 0x3F -> IllegalOp=1, ALUControl=0, no write controls.
- Force BubbleCount to 0xFFFF, then flush -> stays 0xFFFF.
